// File: rtl/muldiv_if.sv
// Handshake between the EX stage and the multi-cycle RV32M sequencer.
// The EX stage is the master and the sequencer is the slave.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            kill;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, kill,
        input  busy, stall, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, kill,
        output busy, stall, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: shift-add multiply and restoring divide on operand
// magnitudes, with the sign fixed up once on the final iteration.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_pending;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic [4:0]        r_rd;

    logic              w_accept;
    logic              w_aSigned;
    logic              w_bSigned;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [XLEN-1:0]   w_aMag;
    logic [XLEN-1:0]   w_bMag;
    logic              w_divZero;
    logic              w_divOvf;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mulNext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_divVal;
    logic [XLEN-1:0]   w_divFinal;
    logic [XLEN-1:0]   w_mulFinal;

    assign w_accept  = bus.start & ~bus.kill & (r_state == S_IDLE);
    assign w_aSigned = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign w_bSigned = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    assign w_aNeg    = w_aSigned & bus.op_a[XLEN-1];
    assign w_bNeg    = w_bSigned & bus.op_b[XLEN-1];
    assign w_aMag    = w_aNeg ? -bus.op_a : bus.op_a;
    assign w_bMag    = w_bNeg ? -bus.op_b : bus.op_b;
    assign w_divZero = bus.funct3[2] & (bus.op_b == '0);
    assign w_divOvf  = bus.funct3[2] & ~bus.funct3[0] & (&bus.op_b)
                     & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}});

    // Multiply: r_lo holds the multiplier shifting out, r_hi the growing partial product
    assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mulNext  = {w_sum, r_lo[XLEN-1:1]};
    assign w_prod     = r_neg ? -w_mulNext : w_mulNext;
    assign w_mulFinal = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Divide: r_lo shifts dividend bits out and quotient bits in, r_hi is the remainder
    assign w_shift    = {r_hi, r_lo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_ge       = ~w_diff[XLEN];
    assign w_quot     = {r_lo[XLEN-2:0], w_ge};
    assign w_rem      = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_divVal   = r_funct3[1] ? w_rem : w_quot;
    assign w_divFinal = r_neg ? -w_divVal : w_divVal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_pending <= '0;
            r_result  <= '0;
            r_funct3  <= '0;
            r_neg     <= 1'b0;
            r_rd      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd     <= bus.rd_in;
                        r_funct3 <= bus.funct3;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        if (w_divZero) begin
                            r_pending <= bus.funct3[1] ? bus.op_a : '1;
                            r_state   <= S_DONE;
                        end else if (w_divOvf) begin
                            r_pending <= bus.funct3[1] ? '0 : bus.op_a;
                            r_state   <= S_DONE;
                        end else if (bus.funct3[2]) begin
                            r_lo    <= w_aMag;
                            r_b     <= w_bMag;
                            r_neg   <= bus.funct3[1] ? w_aNeg : (w_aNeg ^ w_bNeg);
                            r_state <= S_DIV;
                        end else begin
                            r_lo    <= w_bMag;
                            r_b     <= w_aMag;
                            r_neg   <= w_aNeg ^ w_bNeg;
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        {r_hi, r_lo} <= w_mulNext;
                        r_cnt        <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_pending <= w_mulFinal;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (bus.kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_rem;
                        r_lo  <= w_quot;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_pending <= w_divFinal;
                            r_state   <= S_DONE;
                        end
                    end
                end
                default: begin
                    // The pending value only becomes the held result if the write-back survived
                    if (!bus.kill) begin
                        r_result <= r_pending;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == S_MUL) | (r_state == S_DIV);
    assign bus.stall  = (bus.start & ~bus.kill & ~reset & (r_state == S_IDLE)) | bus.busy;
    assign bus.done   = (r_state == S_DONE) & ~bus.kill;
    assign bus.result = (r_state == S_DONE) ? r_pending : r_result;
    assign bus.rd_out = r_rd;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed test of the RV32M sequencer: arithmetic vectors, divide special
// cases, latency, kill and reset behaviour against hand-computed values.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Issues one op, counts cycles to done and stall cycles, then checks the write-back
    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] expRes, input int expLat);
        int lat;
        int stallCnt;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        #1;
        stallCnt = bus.stall ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = 32'hDEADBEEF;
        bus.op_b  = 32'h0BADF00D;
        bus.rd_in = 5'd31;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (bus.stall) stallCnt++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "_result"}, 64'(bus.result), 64'(expRes));
        checkOutput({tag, "_rd"}, 64'(bus.rd_out), 64'(rd));
        checkOutput({tag, "_stallCycles"}, 64'(stallCnt), 64'(expLat));
        checkOutput({tag, "_stallInDone"}, 64'(bus.stall), 64'd0);
    endtask

    // Watches a window of cycles and reports any done pulse
    task automatic expectNoDone(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checkOutput(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.kill   = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        bus.rd_in  = 5'd9;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_stall", 64'(bus.stall), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_result", 64'(bus.result), 64'd0);
        checkOutput("reset_rd", 64'(bus.rd_out), 64'd0);
        bus.start = 1'b0;
        reset     = 1'b0;

        applyStimulus("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        applyStimulus("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
        @(negedge clk);
        checkOutput("done_oneCycle", 64'(bus.done), 64'd0);
        checkOutput("result_held", 64'(bus.result), 64'h00000000FFFFFFFE);
        checkOutput("rd_held", 64'(bus.rd_out), 64'd6);
        applyStimulus("mulh_m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
        applyStimulus("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        applyStimulus("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 33);
        applyStimulus("mulhsu_min", 3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 33);
        applyStimulus("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 33);
        applyStimulus("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 33);
        applyStimulus("div_negb",   3'b100, 32'd20,       32'hFFFFFFFD, 5'd13, 32'hFFFFFFFA, 33);
        applyStimulus("rem_negb",   3'b110, 32'd20,       32'hFFFFFFFD, 5'd14, 32'd2,        33);
        applyStimulus("divu_zero",  3'b101, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
        applyStimulus("rem_zero",   3'b110, 32'd5,        32'd0,        5'd16, 32'd5,        1);
        applyStimulus("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
        applyStimulus("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1);
        applyStimulus("remu_small", 3'b111, 32'd100,      32'd7,        5'd19, 32'd2,        33);
        applyStimulus("divu_small", 3'b101, 32'd100,      32'd7,        5'd20, 32'd14,       33);

        // Kill ten cycles into a divide
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        bus.rd_in  = 5'd21;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("kill_busyBefore", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checkOutput("kill_busy", 64'(bus.busy), 64'd0);
        checkOutput("kill_stall", 64'(bus.stall), 64'd0);
        checkOutput("kill_result", 64'(bus.result), 64'd14);
        expectNoDone("kill_noDone", 40);
        checkOutput("kill_resultLater", 64'(bus.result), 64'd14);

        // Start and kill together in IDLE must not be accepted
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        bus.funct3 = 3'b000;
        #1;
        checkOutput("startKill_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        checkOutput("startKill_busy", 64'(bus.busy), 64'd0);
        expectNoDone("startKill_noDone", 40);

        // Reset in the middle of a multiply
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd6;
        bus.op_b   = 32'd7;
        bus.rd_in  = 5'd22;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_busyBefore", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_stall", 64'(bus.stall), 64'd0);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_rd", 64'(bus.rd_out), 64'd0);
        expectNoDone("rst_noDone", 40);

        // Back-to-back ops: the second start lands in the IDLE cycle right after DONE
        applyStimulus("b2b_first",  3'b000, 32'd6,        32'd7,        5'd23, 32'd42,       33);
        applyStimulus("b2b_second", 3'b111, 32'd43,       32'd5,        5'd24, 32'd3,        33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
